// File: rtl/muldiv_arbiter.sv
// Shares one multi-cycle mul/div unit between the EX pipes of the dual-issue core.
// Latency: start pulse one cycle after a grant in IDLE; done_o the cycle after unit_finished_i.
// Backpressure: stall_o holds EX while a requesting pipe has no result; unit_ready_i gates issue.
module muldiv_arbiter #(
  parameter int NUM_PIPE = 2,
  parameter int DATA_W   = 32,
  parameter int PARA_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         advance_i,
  input  logic [NUM_PIPE-1:0]          req_i,
  input  logic [NUM_PIPE*PARA_W-1:0]   para_i,
  input  logic [NUM_PIPE*DATA_W-1:0]   rs0_i,
  input  logic [NUM_PIPE*DATA_W-1:0]   rs1_i,
  output logic [NUM_PIPE-1:0]          done_o,
  output logic [NUM_PIPE*DATA_W-1:0]   result_o,
  output logic                         stall_o,
  output logic                         unit_start_o,
  output logic [PARA_W-1:0]            unit_para_o,
  output logic [DATA_W-1:0]            unit_rs0_o,
  output logic [DATA_W-1:0]            unit_rs1_o,
  input  logic                         unit_ready_i,
  input  logic                         unit_finished_i,
  input  logic [DATA_W-1:0]            unit_data_i,
  output logic                         unit_ack_o,
  output logic                         unit_clear_o
);

  localparam int OWN_W = (NUM_PIPE > 1) ? $clog2(NUM_PIPE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [OWN_W-1:0]                owner_q, owner_d;
  logic [PARA_W-1:0]               para_q, para_d;
  logic [DATA_W-1:0]               rs0_q, rs0_d;
  logic [DATA_W-1:0]               rs1_q, rs1_d;
  logic [NUM_PIPE-1:0]             done_q, done_d;
  logic [NUM_PIPE-1:0][DATA_W-1:0] result_q, result_d;

  // Per-pipe views of the flat operand buses
  logic [NUM_PIPE-1:0][PARA_W-1:0] para_v;
  logic [NUM_PIPE-1:0][DATA_W-1:0] rs0_v;
  logic [NUM_PIPE-1:0][DATA_W-1:0] rs1_v;

  assign para_v = para_i;
  assign rs0_v  = rs0_i;
  assign rs1_v  = rs1_i;

  logic [NUM_PIPE-1:0] elig;
  logic                grant_vld;
  logic [OWN_W-1:0]    grant_idx;

  // Fixed-priority grant: the lowest-index pipe still lacking a result wins
  always_comb begin
    elig      = req_i & ~done_q;
    grant_vld = |elig;
    grant_idx = '0;
    for (int i = NUM_PIPE - 1; i >= 0; i--) begin
      if (elig[i]) grant_idx = OWN_W'(i);
    end
  end

  // Stall is gated in reset so every output reads 0 while rst is held
  assign stall_o = ~rst & grant_vld;

  // Next-state and unit handshake; flush overrides capture and advance
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    para_d       = para_q;
    rs0_d        = rs0_q;
    rs1_d        = rs1_q;
    result_d     = result_q;
    done_d       = advance_i ? '0 : done_q;
    unit_start_o = 1'b0;
    unit_ack_o   = 1'b0;
    unit_clear_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld && unit_ready_i) begin
          owner_d = grant_idx;
          para_d  = para_v[grant_idx];
          rs0_d   = rs0_v[grant_idx];
          rs1_d   = rs1_v[grant_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        unit_start_o = 1'b1;
        state_d      = S_BUSY;
      end
      S_BUSY: begin
        // A finish seen in any other state is stale and simply ignored
        if (unit_finished_i) begin
          unit_ack_o        = 1'b1;
          result_d[owner_q] = unit_data_i;
          done_d[owner_q]   = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d      = S_IDLE;
      done_d       = '0;
      result_d     = result_q;
      unit_start_o = 1'b0;
      unit_ack_o   = 1'b0;
      unit_clear_o = (state_q != S_IDLE);
    end

    if (rst) begin
      unit_start_o = 1'b0;
      unit_ack_o   = 1'b0;
      unit_clear_o = 1'b0;
    end
  end

  // State and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      para_q   <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      para_q   <= para_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done_o      = done_q;
  assign result_o    = result_q;
  assign unit_para_o = para_q;
  assign unit_rs0_o  = rs0_q;
  assign unit_rs1_o  = rs1_q;

  // EX must not advance past an unfinished op, nor drop the owner's request mid-operation
  a_adv_no_stall: assert property (@(posedge clk) disable iff (rst) advance_i |-> !stall_o);
  a_req_held:     assert property (@(posedge clk) disable iff (rst)
                                   (state_q == S_BUSY && !flush_i) |-> req_i[owner_q]);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural 4-cycle mul/div unit.
// Single ops run from a vector table; dual issue, not-ready, flush and reset by hand.
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_muldiv_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             advance = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0][2:0]  para_v = '0;
  logic [1:0][31:0] rs0_v = '0;
  logic [1:0][31:0] rs1_v = '0;
  logic [1:0]       done_o;
  logic [1:0][31:0] res_v;
  logic             stall_o, unit_start_o, unit_ack_o, unit_clear_o;
  logic [2:0]       unit_para_o;
  logic [31:0]      unit_rs0_o, unit_rs1_o;
  logic             unit_ready_i, unit_finished_i;
  logic [31:0]      unit_data_i;

  always #5 clk = ~clk;

  muldiv_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush), .advance_i(advance),
    .req_i(req), .para_i(para_v), .rs0_i(rs0_v), .rs1_i(rs1_v),
    .done_o(done_o), .result_o(res_v), .stall_o(stall_o),
    .unit_start_o(unit_start_o), .unit_para_o(unit_para_o),
    .unit_rs0_o(unit_rs0_o), .unit_rs1_o(unit_rs1_o),
    .unit_ready_i(unit_ready_i), .unit_finished_i(unit_finished_i),
    .unit_data_i(unit_data_i), .unit_ack_o(unit_ack_o), .unit_clear_o(unit_clear_o)
  );

  // ---------------- behavioural mul/div unit ----------------
  logic        ready_en = 1'b1;
  logic        ignore_clear = 1'b0;
  logic        m_kill = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_fin = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  int          n_start = 0;

  function automatic logic [31:0] mdu(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (p)
      3'd0: begin prod = a * b; return prod[31:0]; end
      3'd1: begin prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return prod[63:32]; end
      3'd3: begin prod = {32'd0, a} * {32'd0, b}; return prod[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : 32'($signed(a) % $signed(b));
      3'd7: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  assign unit_ready_i    = ready_en & ~m_busy;
  assign unit_finished_i = m_fin;
  assign unit_data_i     = m_res;

  always @(posedge clk) begin
    if (unit_start_o) n_start <= n_start + 1;
    if (rst || m_kill || (unit_clear_o && !ignore_clear)) begin
      m_busy <= 1'b0; m_fin <= 1'b0; m_cnt <= 0;
    end else if (unit_start_o) begin
      m_busy <= 1'b1; m_fin <= 1'b0; m_cnt <= 2;
      m_res  <= mdu(unit_para_o, unit_rs0_o, unit_rs1_o);
    end else if (m_busy && !m_fin) begin
      if (m_cnt == 0) m_fin <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end else if (m_fin && unit_ack_o) begin
      m_fin <= 1'b0; m_busy <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for the ack, then checks the captured result and retires the op via advance
  task automatic finish_op(input int p, input logic [31:0] exp, input string nm);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(); @(negedge clk);
      if (unit_ack_o) begin seen = 1; break; end
    end
    chk({nm, "_ack_seen"}, 64'(seen), 64'd1);
    cyc(); @(negedge clk);
    chk({nm, "_done"}, 64'(done_o), 64'(2'b01 << p));
    chk({nm, "_result"}, 64'(res_v[p]), 64'(exp));
    chk({nm, "_stall_low"}, 64'(stall_o), 64'd0);
    chk({nm, "_ack_single"}, 64'(unit_ack_o), 64'd0);
    advance = 1'b1;
    cyc(); advance = 1'b0; req[p] = 1'b0;
    @(negedge clk);
    chk({nm, "_done_clr"}, 64'(done_o), 64'd0);
    chk({nm, "_result_kept"}, 64'(res_v[p]), 64'(exp));
  endtask

  task automatic run_op(input int p, input logic [2:0] pm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string nm);
    cyc();
    req[p] = 1'b1; para_v[p] = pm; rs0_v[p] = a; rs1_v[p] = b;
    @(negedge clk);
    chk({nm, "_stall"}, 64'(stall_o), 64'd1);
    chk({nm, "_no_early_start"}, 64'(unit_start_o), 64'd0);
    cyc(); @(negedge clk);
    chk({nm, "_start"}, 64'(unit_start_o), 64'd1);
    chk({nm, "_para"}, 64'(unit_para_o), 64'(pm));
    chk({nm, "_rs0"}, 64'(unit_rs0_o), 64'(a));
    chk({nm, "_rs1"}, 64'(unit_rs1_o), 64'(b));
    finish_op(p, exp, nm);
  endtask

  typedef struct {
    int          pipe;
    logic [2:0]  pm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s0;
    bit got;
    vecs[0]  = '{0, 3'd0, 32'd7,          32'd6,          32'd42};
    vecs[1]  = '{1, 3'd0, 32'hFFFF_FFFF,  32'd5,          32'hFFFF_FFFB};
    vecs[2]  = '{0, 3'd1, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF};
    vecs[3]  = '{1, 3'd3, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
    vecs[4]  = '{0, 3'd4, 32'd100,        32'd7,          32'd14};
    vecs[5]  = '{1, 3'd4, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
    vecs[6]  = '{0, 3'd5, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF};
    vecs[7]  = '{1, 3'd6, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{0, 3'd6, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
    vecs[9]  = '{1, 3'd7, 32'hFFFF_FFFF,  32'd10,         32'd5};
    vecs[10] = '{0, 3'd5, 32'd1234,       32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{1, 3'd6, 32'd9,          32'd0,          32'd9};

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_result", res_v, 64'd0);
    chk("rst_outs", {unit_start_o, unit_ack_o, unit_clear_o, stall_o}, 64'd0);
    chk("rst_unit_regs", {unit_para_o, unit_rs0_o, unit_rs1_o}, 64'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall_o), 64'd0);

    // Single operations from the table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].pipe, vecs[i].pm, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Dual request: pipe0 first, pipe1 latched right after pipe0 completes
    s0 = n_start;
    cyc();
    req = 2'b11;
    para_v[0] = 3'd4; rs0_v[0] = 32'd100; rs1_v[0] = 32'd7;
    para_v[1] = 3'd6; rs0_v[1] = 32'd100; rs1_v[1] = 32'd7;
    @(negedge clk);
    chk("dual_stall", 64'(stall_o), 64'd1);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(); @(negedge clk);
      if (done_o == 2'b01) begin got = 1; break; end
    end
    chk("dual_p0_done", 64'(got), 64'd1);
    chk("dual_p0_result", 64'(res_v[0]), 64'd14);
    chk("dual_p0_stall_held", 64'(stall_o), 64'd1);
    cyc(); @(negedge clk);
    chk("dual_p1_start", 64'(unit_start_o), 64'd1);
    chk("dual_p1_para", 64'(unit_para_o), 64'd6);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(); @(negedge clk);
      if (unit_ack_o) begin got = 1; break; end
    end
    chk("dual_p1_ack", 64'(got), 64'd1);
    cyc(); @(negedge clk);
    chk("dual_done", 64'(done_o), 64'd3);
    chk("dual_p1_result", 64'(res_v[1]), 64'd2);
    chk("dual_stall_low", 64'(stall_o), 64'd0);
    chk("dual_starts", 64'(n_start - s0), 64'd2);
    advance = 1'b1;
    cyc(); advance = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("dual_done_clr", 64'(done_o), 64'd0);

    // Unit not ready for 5 cycles
    ready_en = 1'b0;
    cyc();
    req[1] = 1'b1; para_v[1] = 3'd0; rs0_v[1] = 32'd3; rs1_v[1] = 32'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("nrdy_no_start%0d", k), 64'(unit_start_o), 64'd0);
      chk($sformatf("nrdy_stall%0d", k), 64'(stall_o), 64'd1);
      cyc();
    end
    ready_en = 1'b1;
    @(negedge clk);
    chk("nrdy_rise_no_start", 64'(unit_start_o), 64'd0);
    cyc(); @(negedge clk);
    chk("nrdy_start", 64'(unit_start_o), 64'd1);
    finish_op(1, 32'd15, "nrdy");

    // Flush two cycles after start; the unit finishes late and must be ignored
    ignore_clear = 1'b1;
    s0 = n_start;
    cyc();
    req[0] = 1'b1; para_v[0] = 3'd0; rs0_v[0] = 32'd7; rs1_v[0] = 32'd6;
    cyc(); @(negedge clk);
    chk("fl_start", 64'(unit_start_o), 64'd1);
    cyc();
    cyc(); flush = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("fl_clear", 64'(unit_clear_o), 64'd1);
    chk("fl_no_ack", 64'(unit_ack_o), 64'd0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("fl_clear_single", 64'(unit_clear_o), 64'd0);
    chk("fl_done", 64'(done_o), 64'd0);
    chk("fl_stall", 64'(stall_o), 64'd0);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); @(negedge clk);
      if (unit_finished_i) begin got = 1; break; end
    end
    chk("fl_late_fin_seen", 64'(got), 64'd1);
    chk("fl_late_no_ack", 64'(unit_ack_o), 64'd0);
    cyc(); @(negedge clk);
    chk("fl_late_result", 64'(res_v[0]), 64'd14);
    chk("fl_late_done", 64'(done_o), 64'd0);
    chk("fl_starts", 64'(n_start - s0), 64'd1);
    m_kill = 1'b1;
    cyc(); m_kill = 1'b0; ignore_clear = 1'b0;

    // Flush in the same cycle as unit_finished_i
    cyc();
    req[0] = 1'b1; para_v[0] = 3'd0; rs0_v[0] = 32'd9; rs1_v[0] = 32'd9;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (unit_finished_i) begin flush = 1'b1; req[0] = 1'b0; got = 1; end
      @(negedge clk);
      if (got) break;
    end
    chk("flf_fin_seen", 64'(got), 64'd1);
    chk("flf_clear", 64'(unit_clear_o), 64'd1);
    chk("flf_no_ack", 64'(unit_ack_o), 64'd0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("flf_done", 64'(done_o), 64'd0);
    chk("flf_no_capture", 64'(res_v[0]), 64'd14);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "flf_mulhu");

    // Reset pulse while BUSY
    cyc();
    req[0] = 1'b1; para_v[0] = 3'd0; rs0_v[0] = 32'd7; rs1_v[0] = 32'd6;
    cyc(); cyc();
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("mrst_comb_outs", {unit_start_o, unit_ack_o, unit_clear_o, stall_o}, 64'd0);
    cyc(); rst = 1'b0;
    s0 = n_start;
    @(negedge clk);
    chk("mrst_done", 64'(done_o), 64'd0);
    chk("mrst_result", res_v, 64'd0);
    chk("mrst_unit_regs", {unit_para_o, unit_rs0_o, unit_rs1_o}, 64'd0);
    chk("mrst_outs", {unit_start_o, unit_ack_o, unit_clear_o, stall_o}, 64'd0);
    repeat (5) cyc();
    chk("mrst_no_start", 64'(n_start - s0), 64'd0);
    run_op(1, 3'd0, 32'd12, 32'd12, 32'd144, "mrst_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one multi-cycle mul/div unit between the two EX pipes of the dual-issue core.
- Arbitrates requests and sequences the unit: start, wait, capture result, ack.
- Holds each pipe's result until the EX stage advances, and drives per-pipe stall requests.
- Sits between the two EX instances and the single mul/div unit instance.

Parameters:
- NUM_PIPE, 2, number of requesting EX pipes. Pipe 0 always holds the older instruction.
- DATA_W, 32, operand and result width.
- PARA_W, 3, mul/div mode select width. Encoding: 0 mul, 1 mulh, 3 mulhu, 4 div, 5 divu, 6 mod, 7 modu.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush_i  in  1  pipeline flush. Aborts any in-flight operation.
- advance_i  in  1  EX stage accepts new instructions this cycle.
- req_i  in  NUM_PIPE  pipe i's EX instruction is a mul/div op. Held high until advance.
- para_i  in  NUM_PIPE*PARA_W  mode per pipe. Stable while req high.
- rs0_i  in  NUM_PIPE*DATA_W  operand 0 per pipe.
- rs1_i  in  NUM_PIPE*DATA_W  operand 1 per pipe.
- done_o  in/out: out  NUM_PIPE  result valid for pipe i. Sticky until advance_i or flush_i.
- result_o  out  NUM_PIPE*DATA_W  held result per pipe.
- stall_o  out  1  OR over i of (req_i[i] & ~done_o[i]).
- unit_start_o  out  1  one-cycle start pulse to the unit.
- unit_para_o  out  PARA_W  latched mode.
- unit_rs0_o  out  DATA_W  latched operand 0.
- unit_rs1_o  out  DATA_W  latched operand 1.
- unit_ready_i  in  1  unit idle; high means it may accept a start.
- unit_finished_i  in  1  unit result valid.
- unit_data_i  in  DATA_W  unit result.
- unit_ack_o  out  1  result consumed.
- unit_clear_o  out  1  abort the unit.

Behaviour:
- Reset: rst is synchronous, active-high.
  - Reset returns the FSM to IDLE.
  - All outputs are 0 at reset: done, result, stall regs, unit_start, unit_para/rs0/rs1, unit_ack, unit_clear.
- Eligible pipe i: req_i[i] & ~done_q[i].
- Grant: fixed priority, lowest eligible index (pipe 0 first). Never reissue a pipe whose done_q is set.
- FSM states:
  - IDLE: when any pipe is eligible and unit_ready_i is high, latch owner, para, rs0, rs1, then go to ISSUE. Otherwise stay.
  - ISSUE: unit_start_o=1 for exactly this cycle; go to BUSY.
  - BUSY: wait for unit_finished_i. In the same cycle it arrives:
    - unit_ack_o=1 (combinational, single cycle);
    - result_q[owner] <= unit_data_i;
    - done_q[owner] <= 1;
    - go to IDLE.
- Latency: req seen in IDLE at cycle N → start at N+1 → done_o visible in the cycle after unit_finished_i.
- Back-to-back: if both pipes request in the same cycle, pipe 1 is latched in the first IDLE cycle after pipe 0 completes. stall_o stays high until both done_q bits are set.
- advance_i clears all done_q bits the next cycle. result_q is unchanged.
  - advance_i while stall_o=1 is illegal; flag with an assertion.
- flush_i has highest priority, over finished and advance:
  - next state IDLE and done_q cleared;
  - if the state is ISSUE or BUSY, unit_clear_o=1 for that cycle and unit_start_o is suppressed;
  - a unit_finished_i in the flush cycle is not acked and not captured.
- unit_finished_i outside BUSY is ignored.
- Width rules: no arithmetic in this block. Divide-by-zero semantics belong to the unit; the result passes through unmodified.
- req dropping while owner is BUSY without a flush is illegal; flag with an assertion.

Test Plan:
- Single op: pipe0 mul, 7 * 6. Unit model takes 4 cycles.
  - Expected: unit_start at N+1, unit_ack one cycle, done_o=01, result_o[0]=42.
  - stall_o is high from N until done, then advance_i clears done.
- Dual request: pipe0 div 100/7, pipe1 mod 100/7, both at cycle N.
  - Expected: pipe0 is served first, result 14, done=01 while stall stays high.
  - Then pipe1 is served, result 2, done=11, stall low.
  - The unit sees exactly two start pulses.
- Unit not ready: unit_ready_i low for 5 cycles while pipe1 requests.
  - Expected: no start pulse until ready rises; start 1 cycle after ready; stall held throughout.
- Flush mid-BUSY: flush_i asserted 2 cycles after start.
  - Expected: unit_clear_o=1 for one cycle, FSM back in IDLE, done=00.
  - A late unit_finished_i is ignored: no ack, result_q unchanged.
- Flush coincident with unit_finished_i: expect no capture, no ack, clear asserted.
  - After that, a new request for pipe0 mulhu 0xFFFFFFFF * 2 gives result 0x00000001.
- Reset mid-BUSY: rst pulsed for 1 cycle.
  - Expected: all outputs 0, FSM in IDLE, no start pulse until a new eligible request.
